serial2parallel_rx: RTL and testbench
=====================================

Name: serial2parallel_rx

Overview:
- Receive-side counterpart of the team's 4-bit parallel-to-serial shifter.
- Assembles a serial bit stream, MSB first by default, into WIDTH-bit words.
- Presents each word on a valid/ready output handshake.
- Sits at the far end of the serial link and feeds the downstream parallel consumer; flags end-of-word and overruns.

Parameters:
WIDTH, 4, word length in bits (≥2)
MSB_FIRST, 1, 1 = first received bit lands in parout[WIDTH-1]; 0 = first bit lands in parout[0]

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
serin  input  1  serial data bit
sin_en  input  1  bit strobe; serin sampled on edges where sin_en=1
clr  input  1  synchronous resync/clear of word assembly
parout  output  WIDTH  last completed word
par_valid  output  1  parout holds an unconsumed word
par_ready  input  1  consumer accepts word when par_valid & par_ready
eoc  output  1  one-cycle pulse: word completed on previous edge
overrun  output  1  sticky: unconsumed word was overwritten
bit_cnt  output  $clog2(WIDTH)  bits received in current word

Behaviour:
- Reset (async assert, released synchronously by the system): parout=0, par_valid=0, eoc=0, overrun=0, bit_cnt=0, internal shift register=0. Reset mid-word discards the partial word.
- Bit capture: on an edge with sin_en=1 and clr=0:
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], serin}.
  - MSB_FIRST=0: shreg <= {serin, shreg[WIDTH-1:1]}.
  - bit_cnt increments.
- sin_en=0: shreg and bit_cnt hold. Gaps between bits are legal and unlimited.
- Word completion: an edge with sin_en=1 and bit_cnt==WIDTH-1. On that same edge:
  - parout <= assembled word, including the current serin bit.
  - par_valid <= 1, eoc <= 1, bit_cnt <= 0 (wrap).
  - Latency: word is visible on the cycle immediately after the last bit's sampling edge.
- eoc is high for exactly one cycle per completed word and is independent of the handshake.
- Handshake:
  - Transfer occurs on an edge where par_valid=1 and par_ready=1; par_valid then clears, unless a completion occurs on the same edge.
  - parout holds its value after transfer until the next completion.
  - par_ready is ignored while par_valid=0.
- Simultaneous completion and transfer: par_valid stays 1, parout takes the new word, overrun is not set.
- Completion while par_valid=1 and par_ready=0: parout is overwritten with the new word, par_valid stays 1, overrun <= 1 (sticky).
- clr=1 (synchronous, highest priority after reset):
  - bit_cnt <= 0, shreg <= 0, par_valid <= 0, overrun <= 0, eoc <= 0; parout holds.
  - A bit strobed in the same cycle is discarded. A completion in the same cycle is suppressed.
- No combinational paths from inputs to outputs; all outputs are registered.
- Only two control states are implied: ASSEMBLING, with bit_cnt 0..WIDTH-1, and the par_valid holding flag. No other FSM states.

Test Plan:
- WIDTH=4, MSB_FIRST=1: strobe serin 1,0,1,1 on consecutive cycles, par_ready=1 -> parout=4'hB; par_valid and eoc high exactly one cycle after the 4th bit edge; bit_cnt returns to 0.
- WIDTH=4, MSB_FIRST=0: same bits 1,0,1,1 -> parout=4'hD. Repeat with sin_en=0 gaps of 0–3 cycles between bits -> identical result and a single eoc.
- Back-to-back words 4'hA then 4'h5, par_ready=0 throughout -> after the 2nd word: parout=4'h5, par_valid=1, overrun=1. Then par_ready=1 for one cycle -> par_valid=0; overrun stays 1 until clr.
- par_ready asserted on the exact edge completing a second word (first word 4'h3, second 4'hC) -> par_valid remains 1, parout=4'hC, overrun=0.
- Assert reset asynchronously mid-cycle after 2 bits -> all outputs 0 immediately. Then send 4 bits 0,1,1,0 -> parout=4'h6, so the partial word was discarded.
- clr after 3 bits of a word -> bit_cnt=0, no eoc. Next 4 bits 1,1,1,0 -> parout=4'hE. clr coincident with the 4th bit of a word -> no completion, par_valid=0, prior parout held.

Source files
------------

// File: rtl/serial2parallel_rx.sv
// Serial-to-parallel receiver: assembles strobed serial bits into WIDTH-bit
// words and presents them on a valid/ready handshake with eoc/overrun flags.
module serial2parallel_rx #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     serin,
  input  logic                     sin_en,
  input  logic                     clr,
  output logic [WIDTH-1:0]         parout,
  output logic                     par_valid,
  input  logic                     par_ready,
  output logic                     eoc,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // Output holding flag: S_FULL means parout carries an unconsumed word.
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;
  logic             capture;
  logic             complete;
  logic             transfer;

  // Strobe qualification, completion detect and handshake transfer.
  always_comb begin
    capture  = sin_en & ~clr;
    complete = capture & (bit_cnt == LAST_BIT);
    transfer = (state == S_FULL) & par_ready;
  end

  // Shift register contents after accepting the current serin bit.
  always_comb begin
    shreg_shifted = shreg;
    if (MSB_FIRST) begin
      shreg_shifted = {shreg[WIDTH-2:0], serin};
    end else begin
      shreg_shifted = {serin, shreg[WIDTH-1:1]};
    end
  end

  // Holding-flag state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Holding-flag next state: a completion beats a same-edge transfer.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = S_EMPTY;
    end else if (complete) begin
      state_nxt = S_FULL;
    end else if (transfer) begin
      state_nxt = S_EMPTY;
    end
  end

  assign par_valid = (state == S_FULL);

  // Word assembly, output word capture, eoc pulse and sticky overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      parout  <= '0;
      eoc     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      eoc <= complete;
      if (clr) begin
        shreg   <= '0;
        bit_cnt <= '0;
        overrun <= 1'b0;
      end else if (capture) begin
        shreg   <= shreg_shifted;
        bit_cnt <= complete ? '0 : bit_cnt + CNT_W'(1);
        if (complete) begin
          parout <= shreg_shifted;
          if ((state == S_FULL) && !par_ready) begin
            overrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_serial2parallel_rx.sv
// Bench for serial2parallel_rx: MSB-first and LSB-first instances share the
// same stimulus and are checked against a queue-based word model.
module tb_serial2parallel_rx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         serin;
  logic         sin_en;
  logic         clr;
  logic         par_ready;

  logic [W-1:0] parout_m;
  logic         valid_m;
  logic         eoc_m;
  logic         ovr_m;
  logic [1:0]   cnt_m;
  logic [W-1:0] parout_l;
  logic         valid_l;
  logic         eoc_l;
  logic         ovr_l;
  logic [1:0]   cnt_l;

  int checks   = 0;
  int failures = 0;
  int eoc_seen = 0;

  // Reference model state
  bit q[$];
  int exp_par_m;
  int exp_par_l;
  bit exp_valid;
  bit exp_eoc;
  bit exp_ovr;

  always #5 clk = ~clk;

  serial2parallel_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .serin(serin), .sin_en(sin_en), .clr(clr),
    .parout(parout_m), .par_valid(valid_m), .par_ready(par_ready),
    .eoc(eoc_m), .overrun(ovr_m), .bit_cnt(cnt_m)
  );

  serial2parallel_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .serin(serin), .sin_en(sin_en), .clr(clr),
    .parout(parout_l), .par_valid(valid_l), .par_ready(par_ready),
    .eoc(eoc_l), .overrun(ovr_l), .bit_cnt(cnt_l)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("parout_msb", int'(parout_m), exp_par_m);
    check("parout_lsb", int'(parout_l), exp_par_l);
    check("valid_msb", int'(valid_m), int'(exp_valid));
    check("valid_lsb", int'(valid_l), int'(exp_valid));
    check("eoc_msb", int'(eoc_m), int'(exp_eoc));
    check("eoc_lsb", int'(eoc_l), int'(exp_eoc));
    check("ovr_msb", int'(ovr_m), int'(exp_ovr));
    check("ovr_lsb", int'(ovr_l), int'(exp_ovr));
    check("cnt_msb", int'(cnt_m), q.size());
    check("cnt_lsb", int'(cnt_l), q.size());
  endtask

  // Apply one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input logic s, input logic en, input logic c, input logic r);
    bit xfer;
    int wm;
    int wl;
    @(negedge clk);
    serin = s; sin_en = en; clr = c; par_ready = r;
    xfer    = exp_valid && r;
    exp_eoc = 1'b0;
    if (c) begin
      q.delete();
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
    end else if (en && q.size() == W - 1) begin
      q.push_back(s);
      wm = 0; wl = 0;
      for (int i = 0; i < W; i++) begin
        wm = wm * 2 + int'(q[i]);
        wl = wl + (int'(q[i]) << i);
      end
      exp_par_m = wm;
      exp_par_l = wl;
      if (exp_valid && !r) exp_ovr = 1'b1;
      exp_valid = 1'b1;
      exp_eoc   = 1'b1;
      q.delete();
    end else begin
      if (en) q.push_back(s);
      if (xfer) exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    if (eoc_m) eoc_seen++;
    check_all();
  endtask

  // Send a 4-bit word first-received-bit = bits[3], with random idle gaps.
  task automatic send_word(input logic [3:0] bits, input int gap_max,
                           input logic ready, input logic last_ready);
    for (int i = 0; i < W; i++) begin
      int gaps;
      gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int g = 0; g < gaps; g++) step(1'b0, 1'b0, 1'b0, ready);
      step(bits[3-i], 1'b1, 1'b0, (i == W - 1) ? last_ready : ready);
    end
  endtask

  initial begin
    reset = 1'b1; serin = 1'b0; sin_en = 1'b0; clr = 1'b0; par_ready = 1'b0;
    q.delete();
    exp_par_m = 0; exp_par_l = 0; exp_valid = 0; exp_eoc = 0; exp_ovr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all();

    // Basic word 1,0,1,1 with consumer ready
    send_word(4'b1011, 0, 1'b1, 1'b1);
    check("basic_msb_B", int'(parout_m), 'hB);
    check("basic_lsb_D", int'(parout_l), 'hD);
    check("basic_eoc", int'(eoc_m), 1);
    check("basic_valid", int'(valid_m), 1);
    check("basic_cnt0", int'(cnt_m), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("basic_eoc_once", int'(eoc_m), 0);
    check("basic_consumed", int'(valid_m), 0);

    // Same bits with random gaps of 0..3 cycles: one eoc, same words
    eoc_seen = 0;
    send_word(4'b1011, 3, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("gap_lsb_D", int'(parout_l), 'hD);
    check("gap_single_eoc", eoc_seen, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back A then 5 with no consumer: overrun
    send_word(4'hA, 0, 1'b0, 1'b0);
    send_word(4'h5, 0, 1'b0, 1'b0);
    check("ovr_parout5", int'(parout_m), 'h5);
    check("ovr_valid", int'(valid_m), 1);
    check("ovr_set", int'(ovr_m), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_consumed", int'(valid_m), 0);
    check("ovr_sticky", int'(ovr_m), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr_clr", int'(ovr_m), 0);

    // Completion coincident with transfer: no overrun
    send_word(4'h3, 0, 1'b0, 1'b0);
    send_word(4'hC, 0, 1'b0, 1'b1);
    check("coinc_valid", int'(valid_m), 1);
    check("coinc_parC", int'(parout_m), 'hC);
    check("coinc_no_ovr", int'(ovr_m), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Async reset mid-word after 2 bits
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    sin_en = 1'b0; clr = 1'b0; par_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    q.delete();
    exp_par_m = 0; exp_par_l = 0; exp_valid = 0; exp_eoc = 0; exp_ovr = 0;
    check("rst_parout", int'(parout_m), 0);
    check("rst_cnt", int'(cnt_m), 0);
    check("rst_valid", int'(valid_m), 0);
    check_all();
    @(negedge clk);
    reset = 1'b0;
    send_word(4'b0110, 0, 1'b0, 1'b0);
    check("rst_discard_6", int'(parout_m), 'h6);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // clr after 3 bits, then a fresh word 1,1,1,0
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_cnt0", int'(cnt_m), 0);
    check("clr_no_eoc", int'(eoc_m), 0);
    send_word(4'hE, 0, 1'b0, 1'b0);
    check("clr_word_E", int'(parout_m), 'hE);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // clr coincident with the 4th bit suppresses completion
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("clr4_no_eoc", int'(eoc_m), 0);
    check("clr4_valid0", int'(valid_m), 0);
    check("clr4_hold_E", int'(parout_m), 'hE);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom), 1'($urandom_range(9, 0) < 6), 1'($urandom_range(19, 0) == 0),
           1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
